// File: rtl/teclado_matricial_if.sv
// Key interface between the keypad scanner (producer) and its consumer.
// It carries the key code, the one-cycle valid strobe and the held level.
interface teclado_matricial_if;
    logic [3:0] tecla_atual;
    logic       ativo;
    logic       pressionada;

    modport master (output tecla_atual, ativo, pressionada);
    modport slave  (input  tecla_atual, ativo, pressionada);
endinterface

// File: rtl/teclado_matricial.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces press and release,
// and reports one key code with a single-cycle strobe per physical press.
module teclado_matricial #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  linhas_n,
    output logic [3:0]                  colunas_n,
    teclado_matricial_if.master         key_if
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    // Key codes indexed by {row, col}; '*' = 10, '#' = 11, A..D = 12..15.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'd1,  4'd2, 4'd3,  4'd12,
        4'd4,  4'd5, 4'd6,  4'd13,
        4'd7,  4'd8, 4'd9,  4'd14,
        4'd10, 4'd0, 4'd11, 4'd15
    };

    typedef enum logic [1:0] {SCAN, DEB_PRESS, WAIT_REL} state_t;

    state_t        r_state;
    logic [3:0]    r_meta;
    logic [3:0]    r_rs;
    logic [1:0]    r_col;
    logic [1:0]    r_row;
    logic [SW-1:0] r_slot;
    logic [DW-1:0] r_deb;
    logic [3:0]    r_colunas_n;
    logic [3:0]    r_tecla;
    logic          r_ativo;
    logic          r_press;

    logic          w_any_low;
    logic [1:0]    w_low_row;
    logic [1:0]    w_next_col;
    logic [3:0]    w_next_drive;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_any_low = ~&r_rs;
        w_low_row = 2'd3;
        if (!r_rs[2]) w_low_row = 2'd2;
        if (!r_rs[1]) w_low_row = 2'd1;
        if (!r_rs[0]) w_low_row = 2'd0;
        w_next_col   = r_col + 2'd1;
        w_next_drive = ~(4'b0001 << w_next_col);
    end

    // Idle rows read high, so the synchronizer resets to all-ones to avoid a phantom press.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_meta      <= 4'hF;
            r_rs        <= 4'hF;
            r_col       <= 2'd0;
            r_row       <= 2'd0;
            r_slot      <= '0;
            r_deb       <= '0;
            r_colunas_n <= 4'b1110;
            r_tecla     <= 4'd0;
            r_ativo     <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            r_meta  <= linhas_n;
            r_rs    <= r_meta;
            r_ativo <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_slot != SLOT_LAST) begin
                        r_slot <= r_slot + SW'(1);
                    end else if (!w_any_low) begin
                        r_col       <= w_next_col;
                        r_colunas_n <= w_next_drive;
                        r_slot      <= '0;
                    end else begin
                        r_row   <= w_low_row;
                        r_deb   <= '0;
                        r_slot  <= '0;
                        r_state <= DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (r_rs[r_row]) begin
                        // Bounce: give up on this key and keep scanning from the next column.
                        r_state     <= SCAN;
                        r_col       <= w_next_col;
                        r_colunas_n <= w_next_drive;
                        r_slot      <= '0;
                        r_deb       <= '0;
                    end else if (r_deb == DEB_LAST) begin
                        r_ativo <= 1'b1;
                        r_tecla <= KEY_MAP[{r_row, r_col}];
                        r_press <= 1'b1;
                        r_deb   <= '0;
                        r_state <= WAIT_REL;
                    end else begin
                        r_deb <= r_deb + DW'(1);
                    end
                end
                WAIT_REL: begin
                    if (w_any_low) begin
                        r_deb <= '0;
                    end else if (r_deb == DEB_LAST) begin
                        r_press     <= 1'b0;
                        r_state     <= SCAN;
                        r_col       <= w_next_col;
                        r_colunas_n <= w_next_drive;
                        r_slot      <= '0;
                        r_deb       <= '0;
                    end else begin
                        r_deb <= r_deb + DW'(1);
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign colunas_n          = r_colunas_n;
    assign key_if.tecla_atual = r_tecla;
    assign key_if.ativo       = r_ativo;
    assign key_if.pressionada = r_press;
endmodule

// File: tb/tb_teclado_matricial.sv
// Self-checking bench for teclado_matricial: a keypad model closes the row/column loop and
// a queue of expected key codes is checked against each ativo pulse.
module tb_teclado_matricial;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] linhas_n;
    logic [3:0] colunas_n;
    logic [15:0] keys;  // bit row*4+col set = key held

    teclado_matricial_if key_bus ();

    logic [3:0] tecla_atual;
    logic       ativo;
    logic       pressionada;
    assign tecla_atual = key_bus.tecla_atual;
    assign ativo       = key_bus.ativo;
    assign pressionada = key_bus.pressionada;

    teclado_matricial #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .linhas_n  (linhas_n),
        .colunas_n (colunas_n),
        .key_if    (key_bus)
    );

    always #5 clk = ~clk;

    // Keypad: a row reads low when a held key in it sits on the driven column.
    always_comb begin
        linhas_n = 4'hF;
        for (int r = 0; r < 4; r++)
            linhas_n[r] = ~|(keys[r*4 +: 4] & ~colunas_n);
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic       prev_ativo = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every pulse must match the oldest outstanding press.
    initial begin
        forever begin
            @(negedge clk);
            if (ativo === 1'b1) begin
                check("ativo_spacing", prev_ativo, 0);
                if (exp_q.size() > 0) begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("tecla_at_pulse", tecla_atual, e);
                    check("press_at_pulse", pressionada, 1);
                end else begin
                    check("spurious_ativo", ativo, 0);
                end
            end
            prev_ativo = ativo;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c, input logic [3:0] code);
        exp_q.push_back(code);
        keys[r*4 + c] = 1'b1;
    endtask

    task automatic wait_pulses(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic release_all();
        keys = '0;
        tick(16);
    endtask

    // Returns #1 after the edge on which column 0 becomes driven (slot counter then 0).
    task automatic wait_col0(input string tag);
        logic [3:0] prev;
        int k = 0;
        prev = colunas_n;
        while (k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (colunas_n == 4'b1110 && prev != 4'b1110) break;
            prev = colunas_n;
        end
        check(tag, colunas_n, 4'b1110);
    endtask

    initial begin
        logic [3:0] exp_cols;
        logic [3:0] seq_code [3];
        int         seq_r [3];
        int         seq_c [3];
        seq_code = '{4'd7, 4'd11, 4'd3};
        seq_r    = '{2, 3, 0};
        seq_c    = '{0, 2, 2};

        keys  = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_colunas", colunas_n, 4'b1110);
        check("rst_tecla", tecla_atual, 0);
        check("rst_ativo", ativo, 0);
        check("rst_press", pressionada, 0);

        // Idle scan: each column held for 4 cycles, in order.
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            exp_cols = ~(4'b0001 << ((n / 4) % 4));
            check("scan_col", colunas_n, exp_cols);
        end

        // Key 6 held long: one pulse, release debounce boundary, resume at c3.
        press(1, 2, 4'd6);
        wait_pulses("pulse_6", 200);
        tick(60);
        check("hold_press_6", pressionada, 1);
        check("hold_tecla_6", tecla_atual, 6);
        keys = '0;
        tick(8);
        check("release_not_yet", pressionada, 1);
        tick(4);
        check("release_done", pressionada, 0);
        check("resume_c3", colunas_n, 4'b0111);
        tick(10);

        // '*' with a one-cycle bounce during press debounce.
        wait_col0("sync_bounce");
        keys[12] = 1'b1;
        tick(4);
        keys[12] = 1'b0;
        tick(1);
        keys[12] = 1'b1;
        tick(2);
        check("bounce_abort_col", colunas_n, 4'b1101);
        exp_q.push_back(4'd10);
        wait_pulses("pulse_star", 200);
        release_all();
        check("star_held", tecla_atual, 10);

        // A and C together in c3: lowest row wins; partial release gives no new pulse.
        keys[3]  = 1'b1;
        keys[11] = 1'b1;
        exp_q.push_back(4'd12);
        wait_pulses("pulse_A", 200);
        keys[3] = 1'b0;
        tick(30);
        check("partial_release_press", pressionada, 1);
        check("partial_release_tecla", tecla_atual, 12);
        release_all();
        check("full_release_press", pressionada, 0);
        press(2, 3, 4'd14);
        wait_pulses("pulse_C", 200);
        release_all();

        // 7, '#', 3 with full release in between; code held after release.
        for (int i = 0; i < 3; i++) begin
            press(seq_r[i], seq_c[i], seq_code[i]);
            wait_pulses("pulse_seq", 200);
            release_all();
            check("seq_held", tecla_atual, seq_code[i]);
            check("seq_released", pressionada, 0);
        end

        // Reset while the press debounce counter sits at 5.
        wait_col0("sync_reset");
        keys[0] = 1'b1;
        tick(9);
        rst_n = 1'b0;
        #1;
        check("midrst_colunas", colunas_n, 4'b1110);
        check("midrst_tecla", tecla_atual, 0);
        check("midrst_ativo", ativo, 0);
        check("midrst_press", pressionada, 0);
        keys = '0;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        check("post_rst_tecla", tecla_atual, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/teclado_matricial.md
Name: teclado_matricial

Overview:
- Scanner/decoder for a 4x4 matrix keypad; producer side of the key interface consumed by the calculator.
- Drives keypad columns one at a time and samples the rows.
- Debounces press and release, then emits one 4-bit key code with a single-cycle valid strobe (ativo) per physical press.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing (>=4).
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a press or release (>=2).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- linhas_n  input  4  keypad rows, active-low, pulled up, asynchronous to clk
- colunas_n  output  4  keypad column drive, active-low, exactly one bit low at all times
- tecla_atual  output  4  code of last accepted key, held until next press
- ativo  output  1  one-cycle pulse, tecla_atual valid in the same cycle
- pressionada  output  1  high from press acceptance until release acceptance

Behaviour:
- Reset (async assert, sync deassert by system): colunas_n=4'b1110, tecla_atual=0, ativo=0, pressionada=0, state SCAN, counters 0.
- linhas_n passes through a 2-flop synchronizer; all logic uses the synchronized rows (rs). Input-to-rs latency is 2 cycles.
- Key map (row r, column c; r0 top, c0 left):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Codes: digits 0-9 = 0..9, '*'=10, '#'=11, A=12, B=13, C=14, D=15.
- State SCAN:
  - Column c is driven for SCAN_DIV cycles; rs is evaluated only in the last cycle of the slot.
  - If no rs bit is low, advance to c+1 with wrap 3->0 and reload the slot counter.
  - If any rs bit is low, latch c and the lowest-index low row r; the column stays driven; go to DEB_PRESS with the counter cleared.
- State DEB_PRESS:
  - Each cycle rs[r] is low, increment the counter.
  - If rs[r] goes high, return to SCAN, advance to the next column, and clear the counter.
  - When the counter reaches DEB_CYCLES: drive ativo=1 for exactly one cycle, load tecla_atual with the code in that same cycle, set pressionada=1, and go to WAIT_REL.
- State WAIT_REL:
  - The column stays driven.
  - Count consecutive cycles in which all four rs bits are high; any low bit clears the count.
  - When the count reaches DEB_CYCLES: pressionada=0, go to SCAN, and resume from column c+1.
- Held keys:
  - A held key produces exactly one ativo pulse, however long it is held.
  - Other keys pressed in the same column while held are ignored.
  - Keys in other columns are invisible while held (no rollover, no repeat).
- Multiple keys: lowest row wins within a column; the column scanned first wins across columns.
- Counters: slot counter is $clog2(SCAN_DIV) bits and debounce counter is $clog2(DEB_CYCLES+1) bits; both saturate and never wrap.
- Reset mid-operation (any state): immediate return to reset values. No partial ativo pulse. tecla_atual is cleared to 0.
- ativo is never high in two consecutive cycles. The minimum spacing between pulses is 2*DEB_CYCLES+SCAN_DIV cycles.
- All outputs are registered. colunas_n changes only on a slot boundary or on a return to SCAN.

Test Plan (SCAN_DIV=4, DEB_CYCLES=8):
- Reset, no keys held for 40 cycles -> colunas_n cycles 1110,1101,1011,0111 every 4 cycles; ativo never high.
- Hold r1 low whenever c2 is driven, for 100 cycles -> exactly one ativo pulse with tecla_atual=6, pressionada=1; after release plus 8+2 cycles, pressionada=0 and scan resumes at c3.
- Press r3/c0 ('*') with a 3-cycle bounce (low, high, low) before a stable low -> first attempt aborts to SCAN; a single ativo pulse follows later with tecla_atual=10.
- r0 and r2 both low in c3 -> tecla_atual=12 (A); releasing only r0 produces no new pulse; a second pulse requires full release.
- Assert rst_n=0 during DEB_PRESS at counter=5 -> outputs return to reset values at once; no ativo pulse; tecla_atual=0.
- Sequence 7, '#', 3 with full release between presses -> three pulses with codes 7, 11, 3, each held on tecla_atual until the next pulse.
